// File: rtl/pc_gen.sv
// pc_gen: instruction-fetch program counter with reset startup,
// flush/branch/jump redirection and a pending-redirect slot that
// remembers a control transfer which arrives while IF is frozen.
module pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_ce,
  output logic        next_is_delayslot,
  output logic        pc_adel
);

  // IDLE: fetch disabled after reset; RUN: normal fetch;
  // PEND: a redirect was seen during a stall and is waiting to be applied.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        inst_ce_q;
  logic        delayslot_q;

  logic        redirect_d;
  logic [31:0] redirect_pc_d;
  logic        ctrl_xfer_d;

  // Redirect request from ID; a jump outranks a taken branch.
  always_comb begin
    redirect_d    = jump_en | (branch_en & branch_taken);
    redirect_pc_d = jump_en ? jump_target : branch_target;
    // The next fetch is a delay slot whenever ID holds any control
    // transfer, whether or not the branch is taken.
    ctrl_xfer_d   = branch_en | jump_en;
  end

  // Fetch state machine with registered pc, chip enable and delay-slot flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register in this block
    // reading pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      inst_ce_q   <= 1'b0;
      delayslot_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Enable fetch at RESET_PC; redirect inputs are ignored here.
          inst_ce_q <= 1'b1;
          state_q   <= RUN;
        end

        RUN: begin
          if (flush) begin
            pc_q        <= flush_pc;
            delayslot_q <= 1'b0;
          end else if (stall) begin
            // Hold pc and delay-slot flag; remember a redirect for later.
            if (redirect_d) begin
              pend_pc_q <= redirect_pc_d;
              state_q   <= PEND;
            end
          end else begin
            pc_q        <= redirect_d ? redirect_pc_d : pc_plus4;
            delayslot_q <= ctrl_xfer_d;
          end
        end

        PEND: begin
          if (flush) begin
            // The exception redirect supersedes the captured target.
            pc_q        <= flush_pc;
            pend_pc_q   <= '0;
            delayslot_q <= 1'b0;
            state_q     <= RUN;
          end else if (!stall) begin
            pc_q        <= pend_pc_q;
            delayslot_q <= 1'b0;
            state_q     <= RUN;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pc                = pc_q;
  assign pc_plus4          = pc_q + 32'd4;
  assign inst_ce           = inst_ce_q;
  assign next_is_delayslot = delayslot_q;
  assign pc_adel           = inst_ce_q & (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen. The driver applies one cycle of
// inputs, advances a behavioural model of the fetch unit and queues the
// outputs expected after the next edge; an independent monitor compares
// them on the falling edge.
module tb_pc_gen;

  localparam logic [31:0] RST_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, branch_en, branch_taken, jump_en;
  logic [31:0] flush_pc, branch_target, jump_target;
  logic [31:0] pc, pc_plus4;
  logic        inst_ce, next_is_delayslot, pc_adel;

  always #5 clk = ~clk;

  pc_gen #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .branch_en         (branch_en),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump_en           (jump_en),
    .jump_target       (jump_target),
    .pc                (pc),
    .pc_plus4          (pc_plus4),
    .inst_ce           (inst_ce),
    .next_is_delayslot (next_is_delayslot),
    .pc_adel           (pc_adel)
  );

  typedef struct {
    int          due;
    logic [31:0] pc;
    logic        ce;
    logic        ds;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  // Reference model: architectural view of the fetch unit.
  logic [31:0] m_pc = RST_PC;
  logic        m_ce = 1'b0;
  logic        m_ds = 1'b0;
  logic        m_fetching = 1'b0;    // first fetch has been enabled
  logic        m_have_pending = 1'b0;
  logic [31:0] m_pending_pc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation that has come due.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc", pc, e.pc);
      check("pc_plus4", pc_plus4, e.pc + 32'd4);
      check("inst_ce", {31'd0, inst_ce}, {31'd0, e.ce});
      check("delayslot", {31'd0, next_is_delayslot}, {31'd0, e.ds});
      check("pc_adel", {31'd0, pc_adel}, {31'd0, e.ce && (e.pc % 4 != 0)});
    end
  end

  // One clock of stimulus: apply inputs, step the model, queue the result.
  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                      input logic be, input logic bt, input logic [31:0] bta,
                      input logic je, input logic [31:0] jta);
    logic        wants_redirect;
    logic [31:0] where;
    exp_t        e;
    rst = r; stall = s; flush = f; flush_pc = fpc;
    branch_en = be; branch_taken = bt; branch_target = bta;
    jump_en = je; jump_target = jta;

    wants_redirect = je || (be && bt);
    where          = je ? jta : bta;
    if (r) begin
      m_pc = RST_PC; m_ce = 0; m_ds = 0; m_fetching = 0; m_have_pending = 0;
    end else if (!m_fetching) begin
      m_fetching = 1; m_ce = 1;
    end else if (f) begin
      m_pc = fpc; m_ds = 0; m_have_pending = 0;
    end else if (s) begin
      if (!m_have_pending && wants_redirect) begin
        m_have_pending = 1; m_pending_pc = where;
      end
    end else if (m_have_pending) begin
      m_pc = m_pending_pc; m_ds = 0; m_have_pending = 0;
    end else begin
      m_pc = wants_redirect ? where : m_pc + 32'd4;
      m_ds = be || je;
    end

    e.due = cyc + 1; e.pc = m_pc; e.ce = m_ce; e.ds = m_ds;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    // Reset, then startup sequence BFC00000, BFC00000(ce), BFC00004, ...
    step(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    step(1, 1, 1, 32'h1234_5678, 1, 1, 32'h0000_0040, 1, 32'h0000_0080);
    idle(5);                                          // pc reaches BFC00010
    // Taken branch, then untaken branch: both mark a delay slot.
    step(0, 0, 0, 32'h0, 1, 1, 32'hBFC00100, 0, 32'h0);
    idle(3);
    step(0, 0, 0, 32'h0, 1, 0, 32'hBFC00200, 0, 32'h0);
    idle(1);
    // Jump held under stall for 3 cycles, then released.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h80001000);
    idle(2);
    // Branch and jump together: jump wins.
    step(0, 0, 0, 32'h0, 1, 1, 32'h11110000, 1, 32'h22220000);
    idle(1);
    // Pending target discarded by flush.
    step(0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h12345670);
    step(0, 1, 0, 32'h0, 1, 1, 32'h0BAD0000, 0, 32'h0);
    step(0, 0, 1, 32'hBFC00380, 0, 0, 32'h0, 1, 32'h0BAD0004);
    idle(3);
    // Flush and redirect together: flush only.
    step(0, 0, 1, 32'h80000180, 1, 1, 32'h0BAD0008, 1, 32'h0BAD000C);
    idle(1);
    // Pending target discarded by reset.
    step(0, 1, 0, 32'h0, 0, 0, 32'h0, 1, 32'h76543210);
    step(1, 1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0);
    idle(4);
    // Wraparound and misaligned fetch.
    step(0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'h0, 0, 32'h0);
    idle(2);
    step(0, 0, 1, 32'h80000002, 0, 0, 32'h0, 0, 32'h0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t1, t2, t3;
      t1 = $urandom; t2 = $urandom; t3 = $urandom;
      if ($urandom_range(3) != 0) begin t1[1:0] = 0; t2[1:0] = 0; t3[1:0] = 0; end
      step($urandom_range(63) == 0, $urandom_range(2) == 0, $urandom_range(9) == 0, t1,
           $urandom_range(3) == 0, 1'($urandom_range(1)), t2,
           $urandom_range(5) == 0, t3);
    end
    idle(2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
